// File: rtl/datapath_pkg.sv
// Shared definitions for the register-file + dual-ALU datapath.
//   WIDTH / NREGS / AW : word width, register count, address width
//   op_e               : ALU opcode, applied per SIMD lane
//   vec_e              : lane mode (2'b11 also selects one 32-bit lane)
package datapath_pkg;
  localparam int WIDTH = 32;
  localparam int NREGS = 16;
  localparam int AW    = $clog2(NREGS);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MOV = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    VEC_32 = 2'b00,
    VEC_16 = 2'b01,
    VEC_8  = 2'b10
  } vec_e;
endpackage

// File: rtl/simd_alu.sv
// SIMD ALU: one 32-bit, two 16-bit or four 8-bit lanes.
//   a, b : operands
//   op   : opcode (op_e encoding)
//   vec  : lane mode (vec_e encoding, 2'b11 behaves as 1x32)
//   y    : combinational result
// Every lane width is computed in parallel and the final mux picks one, so
// carries, borrows and shifted-out bits can never leak between lanes.
module simd_alu
  import datapath_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic [1:0]       vec,
  output logic [WIDTH-1:0] y
);

  logic [2:0][WIDTH-1:0] y_mode;  // [0]=1x32, [1]=2x16, [2]=4x8

  for (genvar m = 0; m < 3; m++) begin : g_mode
    localparam int LW = WIDTH >> m;
    localparam int NL = 1 << m;
    localparam int SW = $clog2(LW);
    for (genvar l = 0; l < NL; l++) begin : g_lane
      logic [LW-1:0] la, lb, ly;
      assign la = a[l*LW +: LW];
      assign lb = b[l*LW +: LW];
      always_comb begin
        ly = la;
        case (op)
          OP_ADD:  ly = la + lb;
          OP_SUB:  ly = la - lb;
          OP_AND:  ly = la & lb;
          OP_OR:   ly = la | lb;
          OP_XOR:  ly = la ^ lb;
          OP_SHL:  ly = la << lb[SW-1:0];
          OP_SHR:  ly = la >> lb[SW-1:0];
          OP_MOV:  ly = la;
          default: ly = la;
        endcase
      end
      assign y_mode[m][l*LW +: LW] = ly;
    end
  end

  always_comb begin
    case (vec)
      VEC_16:  y = y_mode[1];
      VEC_8:   y = y_mode[2];
      default: y = y_mode[0];
    endcase
  end

endmodule

// File: rtl/datapath.sv
// 16 x 32-bit register file feeding two SIMD ALUs with dual write-back.
//   clk, rst_n      : clock, async active-low reset (clears all registers)
//   op, form, vec   : shared opcode, chaining select, lane mode
//   A, B, C, D      : source addresses (C unused when form = 1)
//   zero_reg        : register that reads as zero and ignores writes
//   Y1, Y2, write   : destinations and their enables (write[1] wins on tie)
//   const_a, constant : immediate replaces ALU1 operand a
//   result1, result2  : combinational ALU outputs
module datapath
  import datapath_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       op,
  input  logic             form,
  input  logic [1:0]       vec,
  input  logic [AW-1:0]    A,
  input  logic [AW-1:0]    B,
  input  logic [AW-1:0]    C,
  input  logic [AW-1:0]    D,
  input  logic [AW-1:0]    zero_reg,
  input  logic [AW-1:0]    Y1,
  input  logic [AW-1:0]    Y2,
  input  logic [1:0]       write,
  input  logic             const_a,
  input  logic [WIDTH-1:0] constant,
  output logic [WIDTH-1:0] result1,
  output logic [WIDTH-1:0] result2
);

  logic [WIDTH-1:0] registers [0:NREGS-1];
  logic [WIDTH-1:0] rA, rB, rC, rD;
  logic [WIDTH-1:0] a1, a2;

  assign rA = (A == zero_reg) ? '0 : registers[A];
  assign rB = (B == zero_reg) ? '0 : registers[B];
  assign rC = (C == zero_reg) ? '0 : registers[C];
  assign rD = (D == zero_reg) ? '0 : registers[D];

  assign a1 = const_a ? constant : rA;
  // Chained form feeds ALU1's result straight into ALU2 within the cycle.
  assign a2 = form ? result1 : rC;

  simd_alu u_alu1 (.a(a1), .b(rB), .op(op), .vec(vec), .y(result1));
  simd_alu u_alu2 (.a(a2), .b(rD), .op(op), .vec(vec), .y(result2));

  // Port 2 is written after port 1 so it takes priority on Y1 == Y2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) registers[i] <= '0;
    end else begin
      if (write[0] && (Y1 != zero_reg)) registers[Y1] <= result1;
      if (write[1] && (Y2 != zero_reg)) registers[Y2] <= result2;
    end
  end

endmodule

// File: tb/tb_datapath.sv
module tb_datapath;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  op;
  logic        form;
  logic [1:0]  vec;
  logic [3:0]  A, B, C, D, zero_reg, Y1, Y2;
  logic [1:0]  write;
  logic        const_a;
  logic [31:0] constant;
  logic [31:0] result1, result2;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_regs [0:15];

  datapath dut (
    .clk(clk), .rst_n(rst_n), .op(op), .form(form), .vec(vec),
    .A(A), .B(B), .C(C), .D(D), .zero_reg(zero_reg), .Y1(Y1), .Y2(Y2),
    .write(write), .const_a(const_a), .constant(constant),
    .result1(result1), .result2(result2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; return at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_all(input string tag);
    for (int i = 0; i < 16; i++)
      chk($sformatf("%s_r%0d", tag, i), dut.registers[i], exp_regs[i]);
  endtask

  task automatic wr_imm(input logic [3:0] addr, input logic [31:0] val);
    op = 3'b111; form = 1'b0; vec = 2'b00; const_a = 1'b1; constant = val;
    Y1 = addr; write = 2'b01;
    step();
    write = 2'b00;
    exp_regs[addr] = val;
  endtask

  task automatic alu1(input string tag, input logic [2:0] o, input logic [1:0] v,
                      input logic [31:0] exp);
    op = o; vec = v;
    #1;
    chk(tag, result1, exp);
  endtask

  initial begin
    rst_n = 1'b0; op = 3'b000; form = 1'b0; vec = 2'b00;
    A = 0; B = 0; C = 0; D = 0; zero_reg = 4'd14; Y1 = 0; Y2 = 0;
    write = 2'b00; const_a = 1'b0; constant = 32'd0;
    for (int i = 0; i < 16; i++) exp_regs[i] = 32'd0;

    // Reset state
    #3;
    chk_all("reset");
    chk("reset_result1", result1, 32'd0);
    chk("reset_result2", result2, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Immediate write: r1 = 0 + 5
    op = 3'b000; const_a = 1'b1; constant = 32'd5; A = 0; B = 0; Y1 = 4'd1; write = 2'b01;
    #1;
    chk("imm_result1", result1, 32'd5);
    step();
    write = 2'b00;
    exp_regs[1] = 32'd5;
    chk_all("imm");

    // Dual write, independent form
    wr_imm(4'd2, 32'd7);
    wr_imm(4'd3, 32'd3);
    wr_imm(4'd4, 32'd10);
    wr_imm(4'd5, 32'd4);
    op = 3'b001; form = 1'b0; const_a = 1'b0;
    A = 4'd2; B = 4'd3; C = 4'd4; D = 4'd5; Y1 = 4'd6; Y2 = 4'd7; write = 2'b11;
    #1;
    chk("dual_result1", result1, 32'd4);
    chk("dual_result2", result2, 32'd6);
    chk("no_bypass_r6", dut.registers[6], 32'd0);
    step();
    write = 2'b00;
    chk("dual_r6", dut.registers[6], 32'd4);
    chk("dual_r7", dut.registers[7], 32'd6);

    // Chained form: r8 = (7 + 3) + 4; port 1 disabled so r6 keeps 4
    op = 3'b000; form = 1'b1; Y2 = 4'd8; write = 2'b10;
    #1;
    chk("chain_result2", result2, 32'd14);
    step();
    write = 2'b00; form = 1'b0;
    chk("chain_r8", dut.registers[8], 32'd14);
    chk("chain_r6", dut.registers[6], 32'd4);

    // Vector lanes
    wr_imm(4'd2, 32'h00FF_00FF);
    wr_imm(4'd3, 32'h0001_0001);
    const_a = 1'b0; A = 4'd2; B = 4'd3;
    alu1("add_v8",  3'b000, 2'b10, 32'h0000_0000);
    alu1("add_v32", 3'b000, 2'b00, 32'h0100_0100);
    alu1("add_v16", 3'b000, 2'b01, 32'h0100_0100);
    alu1("add_v11", 3'b000, 2'b11, 32'h0100_0100);
    alu1("and",     3'b010, 2'b00, 32'h0001_0001);
    alu1("or",      3'b011, 2'b00, 32'h00FF_00FF);
    alu1("xor",     3'b100, 2'b00, 32'h00FE_00FE);
    alu1("mov",     3'b111, 2'b00, 32'h00FF_00FF);
    A = 4'd3; B = 4'd2;
    alu1("sub_v8",  3'b001, 2'b10, 32'h0002_0002);
    alu1("sub_v16", 3'b001, 2'b01, 32'hFF02_FF02);
    alu1("sub_v32", 3'b001, 2'b00, 32'hFF01_FF02);
    const_a = 1'b1; B = 4'd3;
    constant = 32'h0101_0101;
    alu1("shl_v8",  3'b101, 2'b10, 32'h0102_0102);
    alu1("shl_v32", 3'b101, 2'b00, 32'h0202_0202);
    constant = 32'h8080_8080;
    alu1("shl_v8_out", 3'b101, 2'b10, 32'h8000_8000);
    alu1("shl_v32_hi", 3'b101, 2'b00, 32'h0101_0100);
    alu1("shr_v8",  3'b110, 2'b10, 32'h8040_8040);
    alu1("shr_v32", 3'b110, 2'b00, 32'h4040_4040);
    vec = 2'b00;

    // zero_reg handling
    wr_imm(4'd2, 32'd7);
    zero_reg = 4'd2; const_a = 1'b0; A = 4'd2; op = 3'b111;
    #1;
    chk("zreg_read", result1, 32'd0);
    chk("zreg_stored", dut.registers[2], 32'd7);
    const_a = 1'b1; constant = 32'd99; Y1 = 4'd2; write = 2'b01;
    step();
    write = 2'b00;
    chk("zreg_write", dut.registers[2], 32'd7);
    zero_reg = 4'd14;

    // Write collision: port 2 wins
    wr_imm(4'd10, 32'd2);
    op = 3'b111; form = 1'b0; const_a = 1'b1; constant = 32'd1; C = 4'd10;
    Y1 = 4'd9; Y2 = 4'd9; write = 2'b11;
    #1;
    chk("coll_result1", result1, 32'd1);
    chk("coll_result2", result2, 32'd2);
    step();
    write = 2'b00;
    exp_regs[9] = 32'd2;
    exp_regs[6] = 32'd4; exp_regs[7] = 32'd6; exp_regs[8] = 32'd14;
    chk_all("pre_rst");

    // Mid-cycle reset clears immediately, before any clock edge
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) exp_regs[i] = 32'd0;
    chk_all("midrst");
    @(negedge clk);
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/datapath.md
Name: datapath

Overview:
- Register-file-plus-dual-ALU datapath: a 16 x 32-bit register file, two SIMD-capable ALU lanes and a two-port write-back.
- Each cycle it reads up to four source registers, computes two results and writes them to up to two destination registers on the rising clock edge.
- Sits between the instruction decoder, which drives every control input, and the rest of the core.

Parameters:
- WIDTH, 32, data word width in bits.
- NREGS, 16, register count; addresses are log2(NREGS) = 4 bits.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- op  in  3  ALU opcode, shared by both ALUs.
- form  in  1  0 = independent ALUs; 1 = chained ALUs.
- vec  in  2  lane mode: 00 = 1x32, 01 = 2x16, 10 = 4x8, 11 = 1x32.
- A, B, C, D  in  4 each  source register addresses.
- zero_reg  in  4  address of the register that reads as zero.
- Y1, Y2  in  4 each  destination register addresses.
- write  in  2  write enables: bit0 -> Y1 port, bit1 -> Y2 port.
- const_a  in  1  1 = replace ALU1 operand a with constant.
- constant  in  32  immediate value.
- result1, result2  out  32 each  combinational ALU results, for observation and forwarding.

Behaviour:
- Storage:
  - Register array named registers[0:15], each 32 bits; it must be hierarchically visible.
  - Async reset (rst_n = 0) clears all 16 entries to 0 immediately.
  - result outputs are combinational, so under reset they reflect the zeroed registers.
- Reads:
  - Combinational, four ports: rA, rB, rC, rD.
  - Any read whose address equals zero_reg returns 0, regardless of the stored contents.
- Operands:
  - ALU1: a1 = const_a ? constant : rA; b1 = rB.
  - form = 0: ALU2 uses a2 = rC, b2 = rD.
  - form = 1: ALU2 uses a2 = result1, b2 = rD; C is ignored. Single cycle, no extra latency.
- op encoding (applied independently per lane):
  - 000 ADD, 001 SUB (a - b).
  - 010 AND, 011 OR, 100 XOR.
  - 101 SHL, 110 SHR logical; shift amount = low log2(lane width) bits of the b lane.
  - 111 MOV (result = a).
- Lanes:
  - Carries, borrows and shifted-out bits never cross lane boundaries.
  - All arithmetic wraps modulo 2^lane width; there are no flags.
- Write-back, at each rising clk edge (when rst_n = 1):
  - write[0] = 1: registers[Y1] <= result1.
  - write[1] = 1: registers[Y2] <= result2.
  - Y1 == Y2 with both enables set: result2 wins.
  - A write addressed to zero_reg is discarded; that entry keeps its stored value.
  - write = 00: no state change.
- Timing:
  - Latency: a written value is readable on the next cycle.
  - There is no internal bypass; a read in the same cycle as the write returns the old value.
- rst_n asserted mid-cycle clears all registers immediately. Deassertion is synchronized externally.

Decomposition:
- Package datapath_pkg:
  - op enum: OP_ADD..OP_MOV.
  - vec enum: VEC_32, VEC_16, VEC_8.
  - WIDTH and NREGS constants.
- One natural sub-module: simd_alu (a, b, op, vec -> y), instantiated twice.
- The register file stays inline.

Test Plan:
- Immediate write: reset, then op = ADD, const_a = 1, constant = 5, A = B = 0, zero_reg = 14, Y1 = 1, write = 01, one clk -> registers[1] == 5, all others 0.
- Dual write, independent form:
  - Setup: r2 = 7, r3 = 3, r4 = 10, r5 = 4.
  - Stimulus: op = SUB, form = 0, A = 2, B = 3, C = 4, D = 5, Y1 = 6, Y2 = 7, write = 11.
  - Required: r6 == 4, r7 == 6.
- Chained form: same registers, op = ADD, form = 1, D = 5, Y2 = 8, write = 10 -> r8 == 7 + 3 + 4 = 14.
- Vector lanes: r2 = 0x00FF_00FF, r3 = 0x0001_0001, op = ADD, vec = 10 -> result1 == 0x0000_0000 (no inter-lane carry); with vec = 00 -> 0x0100_0100.
- zero_reg handling:
  - zero_reg = 2 with r2 = 7 stored -> reading A = 2 with MOV gives result1 == 0.
  - A write to Y1 = 2 leaves registers[2] == 7.
- Write collision and reset: Y1 = Y2 = 9, write = 11, result1 = 1, result2 = 2 -> r9 == 2. Then pulse rst_n low mid-cycle -> all registers == 0 immediately.
